// File: rtl/pbi_pkg.sv
// Shared types and constants for the PBI device-select block.
package pbi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WDLY   = 2'd1,
        RD     = 2'd2,
        WAITLO = 2'd3
    } pbi_state_t;

    localparam int PBI_WR_DLY_DEF      = 6;
    localparam int PBI_SYNC_STAGES_DEF = 2;
    localparam int PBI_SEL_W           = 8;
    localparam int PBI_CNT_W           = 4;

endpackage

// File: rtl/pbi_sync.sv
// Multi-flop synchronizer for an asynchronous level, with one-cycle rise/fall pulses.
module pbi_sync
    import pbi_pkg::*;
#(
    parameter int SYNC_STAGES = PBI_SYNC_STAGES_DEF
) (
    input  logic clk_sys,
    input  logic rst_b,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & edge_q;

endmodule

// File: rtl/pbi_dev_select.sv
// PBI device select: $D1FF select register, EXTSEL_n for the $D800 ROM window, device IRQ.
// Interrupt logic and the $D1FF status read are present only when PBI_IRQ_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a Phi2 rise
// WDLY   | $D1FF write seen, counting down to the DataIn sample point
// RD     | $D1FF read, driving the status byte until Phi2 falls
// WAITLO | cycle not ours (or already handled), waiting for Phi2 to fall
module pbi_dev_select
    import pbi_pkg::*;
#(
    parameter int DEV_ID        = 0,
    parameter int SYNC_STAGES   = PBI_SYNC_STAGES_DEF,
    parameter int WR_SAMPLE_DLY = PBI_WR_DLY_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Phi2,
    input  logic                 RW,
    input  logic                 D1FF_n,
    input  logic                 D8XX_n,
    input  logic [PBI_SEL_W-1:0] DataIn,
    output logic [PBI_SEL_W-1:0] DataOut,
    output logic                 DataOE,
    output logic                 DevSel,
    output logic                 EXTSEL_n,
    input  logic                 IrqReq,
    input  logic                 IrqClr,
    output logic                 IRQ_n
);

    localparam logic [PBI_CNT_W-1:0] WDLY_LOAD = PBI_CNT_W'(WR_SAMPLE_DLY - 1);

    pbi_state_t           state_q, state_nxt;
    logic [PBI_CNT_W-1:0] cnt_q, cnt_nxt;
    logic [PBI_SEL_W-1:0] sel_reg_q;
    logic                 sel_ld;
    logic                 extsel_n_q;
    logic                 phi2_rise, phi2_fall;

    pbi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_phi2_sync (
        .clk_sys  (Clk),
        .rst_b    (Reset_n),
        .async_in (Phi2),
        .rise     (phi2_rise),
        .fall     (phi2_fall)
    );

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        sel_ld    = 1'b0;
        case (state_q)
            IDLE: begin
                if (phi2_rise) begin
                    if (!D1FF_n && !RW) begin
                        state_nxt = WDLY;
                        cnt_nxt   = WDLY_LOAD;
                    end else if (!D1FF_n && RW) begin
`ifdef PBI_IRQ_EN
                        state_nxt = RD;
`else
                        state_nxt = WAITLO;
`endif
                    end else begin
                        state_nxt = WAITLO;
                    end
                end
            end
            WDLY: begin
                // A short Phi2 high phase still commits the write on the fall.
                if (phi2_fall) begin
                    sel_ld    = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt_q == '0) begin
                    sel_ld    = 1'b1;
                    state_nxt = WAITLO;
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            RD:      if (phi2_fall) state_nxt = IDLE;
            WAITLO:  if (phi2_fall) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel_reg_q  <= '0;
            extsel_n_q <= 1'b1;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            extsel_n_q <= !(DevSel && !D8XX_n);
            if (sel_ld) sel_reg_q <= DataIn;
        end
    end

    assign DevSel   = sel_reg_q[DEV_ID];
    assign EXTSEL_n = extsel_n_q;

`ifdef PBI_IRQ_EN
    logic                 irq_rise, irq_fall_unused;
    logic                 irq_pend_q, irq_n_q;
    logic                 data_oe_q;
    logic [PBI_SEL_W-1:0] data_out_q;

    pbi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
        .clk_sys  (Clk),
        .rst_b    (Reset_n),
        .async_in (IrqReq),
        .rise     (irq_rise),
        .fall     (irq_fall_unused)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            irq_pend_q <= 1'b0;
            irq_n_q    <= 1'b1;
            data_oe_q  <= 1'b0;
            data_out_q <= '0;
        end else begin
            // New edge beats a clear in the same cycle so no request is lost.
            if (irq_rise)    irq_pend_q <= 1'b1;
            else if (IrqClr) irq_pend_q <= 1'b0;
            irq_n_q    <= !irq_pend_q;
            data_oe_q  <= (state_nxt == RD);
            data_out_q <= (state_nxt == RD) ? (PBI_SEL_W'(irq_pend_q) << DEV_ID) : '0;
        end
    end

    assign IRQ_n   = irq_n_q;
    assign DataOE  = data_oe_q;
    assign DataOut = data_out_q;
`else
    logic unused_irq;
    assign unused_irq = &{1'b0, IrqReq, IrqClr};
    assign IRQ_n      = 1'b1;
    assign DataOE     = 1'b0;
    assign DataOut    = '0;
`endif

endmodule

// File: tb/tb_pbi_dev_select.sv
// Directed bench for pbi_dev_select: two devices (bits 2 and 5) on a shared PBI bus.
// IRQ scenarios are exercised when PBI_IRQ_EN is defined, the disabled behaviour otherwise.
module tb_pbi_dev_select;

    logic       clk     = 1'b0;
    logic       Reset_n = 1'b1;
    logic       Phi2    = 1'b0;
    logic       RW      = 1'b1;
    logic       D1FF_n  = 1'b1;
    logic       D8XX_n  = 1'b1;
    logic [7:0] DataIn  = 8'h00;
    logic       IrqReq  = 1'b0;
    logic       IrqClr  = 1'b0;

    logic [7:0] dout2, dout5;
    logic       oe2, oe5, sel2, sel5, ext2, ext5, irqn2, irqn5;

    int n_pass  = 0;
    int n_total = 0;

    always #10 clk = ~clk;

    pbi_dev_select #(.DEV_ID(2)) u_dev2 (
        .Clk(clk), .Reset_n(Reset_n), .Phi2(Phi2), .RW(RW), .D1FF_n(D1FF_n),
        .D8XX_n(D8XX_n), .DataIn(DataIn), .DataOut(dout2), .DataOE(oe2),
        .DevSel(sel2), .EXTSEL_n(ext2), .IrqReq(IrqReq), .IrqClr(IrqClr), .IRQ_n(irqn2)
    );

    pbi_dev_select #(.DEV_ID(5)) u_dev5 (
        .Clk(clk), .Reset_n(Reset_n), .Phi2(Phi2), .RW(RW), .D1FF_n(D1FF_n),
        .D8XX_n(D8XX_n), .DataIn(DataIn), .DataOut(dout5), .DataOE(oe5),
        .DevSel(sel5), .EXTSEL_n(ext5), .IrqReq(IrqReq), .IrqClr(IrqClr), .IRQ_n(irqn5)
    );

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    // One full Phi2 cycle: 14 Clk high, 14 Clk low, rise/fall off the Clk edge.
    task automatic bus_cycle(input logic rw_v, input logic d1ff_v, input logic [7:0] d);
        @(posedge clk);
        #5 RW = rw_v; D1FF_n = d1ff_v; DataIn = d;
        #3 Phi2 = 1'b1;
        clks(14);
        #8 Phi2 = 1'b0;
        #5 D1FF_n = 1'b1; RW = 1'b1;
        clks(14);
    endtask

    task automatic test_reset();
        #2 Reset_n = 1'b0;
        clks(3);
        #1;
        n_total++; if (dout2 !== 8'h00) $display("FAIL reset_dataout: got %h want 00", dout2); else n_pass++;
        n_total++; if (oe2 !== 1'b0) $display("FAIL reset_dataoe: got %b want 0", oe2); else n_pass++;
        n_total++; if (sel2 !== 1'b0) $display("FAIL reset_devsel: got %b want 0", sel2); else n_pass++;
        n_total++; if (ext2 !== 1'b1) $display("FAIL reset_extsel_n: got %b want 1", ext2); else n_pass++;
        n_total++; if (irqn2 !== 1'b1) $display("FAIL reset_irq_n: got %b want 1", irqn2); else n_pass++;
        n_total++; if (sel5 !== 1'b0) $display("FAIL reset_devsel5: got %b want 0", sel5); else n_pass++;
        @(negedge clk) Reset_n = 1'b1;
        clks(4);
    endtask

    task automatic test_write_select();
        @(posedge clk);
        #5 RW = 1'b0; D1FF_n = 1'b0; DataIn = 8'h04;
        #3 Phi2 = 1'b1;
        clks(7);
        #1;
        n_total++; if (sel2 !== 1'b0) $display("FAIL write_too_early: DevSel=%b want 0", sel2); else n_pass++;
        clks(4);
        #1;
        n_total++; if (sel2 !== 1'b1) $display("FAIL write_04_dev2: DevSel=%b want 1", sel2); else n_pass++;
        n_total++; if (sel5 !== 1'b0) $display("FAIL write_04_dev5: DevSel=%b want 0", sel5); else n_pass++;
        clks(3);
        #8 Phi2 = 1'b0;
        #5 D1FF_n = 1'b1; RW = 1'b1;
        clks(14);
        bus_cycle(1'b0, 1'b0, 8'h01);
        #1;
        n_total++; if (sel2 !== 1'b0) $display("FAIL write_01_dev2: DevSel=%b want 0", sel2); else n_pass++;
    endtask

    task automatic test_rom_window();
        bus_cycle(1'b0, 1'b0, 8'h24);
        @(negedge clk) D8XX_n = 1'b0;
        #1;
        n_total++; if (ext2 !== 1'b1) $display("FAIL extsel_before_edge: got %b want 1", ext2); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (ext2 !== 1'b0) $display("FAIL extsel_dev2_on: got %b want 0", ext2); else n_pass++;
        n_total++; if (ext5 !== 1'b0) $display("FAIL extsel_dev5_on: got %b want 0", ext5); else n_pass++;
        @(negedge clk) D8XX_n = 1'b1;
        @(posedge clk); #1;
        n_total++; if (ext2 !== 1'b1) $display("FAIL extsel_dev2_off: got %b want 1", ext2); else n_pass++;
        bus_cycle(1'b0, 1'b0, 8'h00);
        @(negedge clk) D8XX_n = 1'b0;
        clks(3); #1;
        n_total++; if (ext2 !== 1'b1) $display("FAIL extsel_desel_dev2: got %b want 1", ext2); else n_pass++;
        n_total++; if (ext5 !== 1'b1) $display("FAIL extsel_desel_dev5: got %b want 1", ext5); else n_pass++;
        @(negedge clk) D8XX_n = 1'b1;
    endtask

    task automatic test_no_side_effects();
        bus_cycle(1'b0, 1'b0, 8'h04);
        bus_cycle(1'b0, 1'b1, 8'h00);
        #1;
        n_total++; if (sel2 !== 1'b1) $display("FAIL other_addr_write: DevSel=%b want 1", sel2); else n_pass++;
        bus_cycle(1'b1, 1'b0, 8'h00);
        #1;
        n_total++; if (sel2 !== 1'b1) $display("FAIL read_keeps_sel: DevSel=%b want 1", sel2); else n_pass++;
    endtask

    // Phi2 high for only 4 Clk: the write must land on the fall, before DataIn changes.
    task automatic test_short_write();
        @(posedge clk);
        #5 RW = 1'b0; D1FF_n = 1'b0; DataIn = 8'h20;
        #3 Phi2 = 1'b1;
        clks(4);
        #8 Phi2 = 1'b0;
        clks(3);
        #5 DataIn = 8'h00; D1FF_n = 1'b1; RW = 1'b1;
        clks(10);
        #1;
        n_total++; if (sel5 !== 1'b1) $display("FAIL short_write_dev5: DevSel=%b want 1", sel5); else n_pass++;
        n_total++; if (sel2 !== 1'b0) $display("FAIL short_write_dev2: DevSel=%b want 0", sel2); else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        bus_cycle(1'b0, 1'b0, 8'h24);
        @(negedge clk) D8XX_n = 1'b0;
        clks(2); #1;
        n_total++; if (ext2 !== 1'b0) $display("FAIL premid_extsel: got %b want 0", ext2); else n_pass++;
        @(posedge clk);
        #5 RW = 1'b0; D1FF_n = 1'b0; DataIn = 8'hFF;
        #3 Phi2 = 1'b1;
        clks(5);
        #3 Reset_n = 1'b0;
        #1;
        n_total++; if (sel2 !== 1'b0) $display("FAIL rst_async_devsel: got %b want 0", sel2); else n_pass++;
        n_total++; if (ext2 !== 1'b1) $display("FAIL rst_async_extsel_n: got %b want 1", ext2); else n_pass++;
        n_total++; if (oe2 !== 1'b0) $display("FAIL rst_async_dataoe: got %b want 0", oe2); else n_pass++;
        n_total++; if (sel5 !== 1'b0) $display("FAIL rst_async_devsel5: got %b want 0", sel5); else n_pass++;
        clks(2);
        Phi2 = 1'b0; D1FF_n = 1'b1; RW = 1'b1; D8XX_n = 1'b1;
        clks(2);
        @(negedge clk) Reset_n = 1'b1;
        clks(14); #1;
        n_total++; if (sel2 !== 1'b0) $display("FAIL rst_no_partial: DevSel=%b want 0", sel2); else n_pass++;
        bus_cycle(1'b0, 1'b0, 8'h04);
        #1;
        n_total++; if (sel2 !== 1'b1) $display("FAIL rst_first_write: DevSel=%b want 1", sel2); else n_pass++;
    endtask

`ifdef PBI_IRQ_EN
    task automatic pulse_clr();
        @(posedge clk); #5 IrqClr = 1'b1;
        @(posedge clk); #5 IrqClr = 1'b0;
    endtask

    task automatic test_status_read();
        pulse_clr();
        @(posedge clk); #5 IrqReq = 1'b1;
        clks(3); #5 IrqReq = 1'b0;
        clks(4); #1;
        n_total++; if (irqn5 !== 1'b0) $display("FAIL irq_n_set: got %b want 0", irqn5); else n_pass++;
        @(posedge clk);
        #5 RW = 1'b1; D1FF_n = 1'b0;
        #3 Phi2 = 1'b1;
        clks(7); #1;
        n_total++; if (oe5 !== 1'b1) $display("FAIL read_dataoe: got %b want 1", oe5); else n_pass++;
        n_total++; if (dout5 !== 8'h20) $display("FAIL read_dataout5: got %h want 20", dout5); else n_pass++;
        n_total++; if (dout2 !== 8'h04) $display("FAIL read_dataout2: got %h want 04", dout2); else n_pass++;
        clks(7);
        #8 Phi2 = 1'b0;
        #5 D1FF_n = 1'b1;
        clks(5); #1;
        n_total++; if (oe5 !== 1'b0) $display("FAIL read_oe_after_fall: got %b want 0", oe5); else n_pass++;
        clks(9);
        pulse_clr();
        clks(2); #1;
        n_total++; if (irqn5 !== 1'b1) $display("FAIL irq_n_clr: got %b want 1", irqn5); else n_pass++;
        @(posedge clk);
        #5 RW = 1'b1; D1FF_n = 1'b0;
        #3 Phi2 = 1'b1;
        clks(7); #1;
        n_total++; if (dout5 !== 8'h00) $display("FAIL read_after_clr: got %h want 00", dout5); else n_pass++;
        n_total++; if (oe5 !== 1'b1) $display("FAIL read2_dataoe: got %b want 1", oe5); else n_pass++;
        clks(7);
        #8 Phi2 = 1'b0;
        #5 D1FF_n = 1'b1;
        clks(14);
    endtask

    // IrqReq rises after edge 0; its edge pulse is live between edges 2 and 3, as is IrqClr.
    task automatic test_set_clear();
        @(posedge clk); #5 IrqReq = 1'b1;
        clks(2); #5 IrqClr = 1'b1;
        @(posedge clk); #5 IrqClr = 1'b0;
        clks(3); #1;
        n_total++; if (irqn5 !== 1'b0) $display("FAIL set_wins_irq_n: got %b want 0", irqn5); else n_pass++;
        IrqReq = 1'b0;
        pulse_clr();
        clks(6);
    endtask
`else
    task automatic test_irq_disabled();
        @(posedge clk); #5 IrqReq = 1'b1;
        clks(3); #5 IrqReq = 1'b0;
        clks(6); #1;
        n_total++; if (irqn5 !== 1'b1) $display("FAIL noirq_irq_n: got %b want 1", irqn5); else n_pass++;
        @(posedge clk);
        #5 RW = 1'b1; D1FF_n = 1'b0;
        #3 Phi2 = 1'b1;
        clks(7); #1;
        n_total++; if (oe5 !== 1'b0) $display("FAIL noirq_dataoe: got %b want 0", oe5); else n_pass++;
        n_total++; if (dout5 !== 8'h00) $display("FAIL noirq_dataout: got %h want 00", dout5); else n_pass++;
        n_total++; if (irqn2 !== 1'b1) $display("FAIL noirq_irq_n2: got %b want 1", irqn2); else n_pass++;
        clks(7);
        #8 Phi2 = 1'b0;
        #5 D1FF_n = 1'b1;
        clks(14);
        bus_cycle(1'b0, 1'b0, 8'h20);
        #1;
        n_total++; if (sel5 !== 1'b1) $display("FAIL noirq_write: DevSel=%b want 1", sel5); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_write_select();
        test_rom_window();
        test_no_side_effects();
        test_short_write();
        test_reset_mid_write();
`ifdef PBI_IRQ_EN
        test_status_read();
        test_set_clear();
`else
        test_irq_disabled();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
